// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction at a time: grant (IDLE), memory access (ACCESS), response (RESP).
module data_mem_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h66000000,
  parameter logic [31:0] LIMIT_ADDR = 32'h660000FC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rd_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rd_o,
  output logic        m1_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rd_i,
  output logic [1:0]  state_o
);

  // Handshake: a requester holds req (with we/addr/wd stable) until it sees a
  // one-cycle gnt pulse; exactly two cycles after gnt it gets a one-cycle rvalid
  // carrying rd/err. Dropping req before gnt withdraws the request entirely.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rr_q;
  logic        id_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        grant;
  logic        gnt_id;
  logic        addr_ok;
  logic        in_access;
  logic        in_resp;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          grant  = 1'b1;
          gnt_id = rr_q;
        end else if (m0_req_i) begin
          grant  = 1'b1;
          gnt_id = 1'b0;
        end else if (m1_req_i) begin
          grant  = 1'b1;
          gnt_id = 1'b1;
        end
        if (grant) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign addr_ok = (addr_q >= BASE_ADDR) && (addr_q <= LIMIT_ADDR) && (addr_q[1:0] == 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q   <= gnt_id;
        we_q   <= gnt_id ? m1_we_i   : m0_we_i;
        addr_q <= gnt_id ? m1_addr_i : m0_addr_i;
        wd_q   <= gnt_id ? m1_wd_i   : m0_wd_i;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (addr_ok && !we_q) ? mem_rd_i : 32'd0;
        err_q   <= ~addr_ok;
      end
      // Hand priority to whichever requester was not just served.
      if (state_q == RESP) rr_q <= ~id_q;
    end
  end

  // Gating with rst_i keeps the write strobe low even before the flops settle.
  assign in_access = (state_q == ACCESS) && !rst_i;
  assign in_resp   = (state_q == RESP);

  assign mem_addr_o = in_access ? addr_q : 32'd0;
  assign mem_wd_o   = in_access ? wd_q   : 32'd0;
  assign mem_we_o   = in_access && we_q && addr_ok;

  assign m0_gnt_o    = grant && !gnt_id;
  assign m1_gnt_o    = grant && gnt_id;
  assign m0_rvalid_o = in_resp && !id_q;
  assign m1_rvalid_o = in_resp && id_q;
  assign m0_rd_o     = m0_rvalid_o ? rdata_q : 32'd0;
  assign m1_rd_o     = m1_rvalid_o ? rdata_q : 32'd0;
  assign m0_err_o    = m0_rvalid_o && err_q;
  assign m1_err_o    = m1_rvalid_o && err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: per-cycle vector table plus directed sequences
// for round-robin alternation and reset during a memory access.
module tb_data_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wd_i, m1_addr_i, m1_wd_i, mem_rd_i;
  logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rd_o, m1_rd_o, mem_addr_o, mem_wd_o;
  logic        mem_we_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wd;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wd, mem_rd;
    logic        gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  logic [0:0] exp_q[$];

  data_mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wd_i(m0_wd_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rd_o(m0_rd_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wd_i(m1_wd_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rd_o(m1_rd_o), .m1_err_o(m1_err_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_we_o(mem_we_o), .mem_rd_i(mem_rd_i),
    .state_o(state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wd_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wd_i = 0; mem_rd_i = 0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic drive_vec(input vec_t x);
    m0_req_i = x.m0_req; m0_we_i = x.m0_we; m0_addr_i = x.m0_addr; m0_wd_i = x.m0_wd;
    m1_req_i = x.m1_req; m1_we_i = x.m1_we; m1_addr_i = x.m1_addr; m1_wd_i = x.m1_wd;
    mem_rd_i = x.mem_rd;
  endtask

  task automatic check_vec(input int i, input vec_t x);
    chk($sformatf("v%0d_gnt0", i), m0_gnt_o, x.gnt0);
    chk($sformatf("v%0d_gnt1", i), m1_gnt_o, x.gnt1);
    chk($sformatf("v%0d_rvalid0", i), m0_rvalid_o, x.rv0);
    chk($sformatf("v%0d_rvalid1", i), m1_rvalid_o, x.rv1);
    chk($sformatf("v%0d_rd0", i), m0_rd_o, x.rd0);
    chk($sformatf("v%0d_rd1", i), m1_rd_o, x.rd1);
    chk($sformatf("v%0d_err0", i), m0_err_o, x.err0);
    chk($sformatf("v%0d_err1", i), m1_err_o, x.err1);
    chk($sformatf("v%0d_mem_we", i), mem_we_o, x.mem_we);
    chk($sformatf("v%0d_mem_addr", i), mem_addr_o, x.mem_addr);
    chk($sformatf("v%0d_mem_wd", i), mem_wd_o, x.mem_wd);
  endtask

  initial begin
    // Transaction 1: m0 valid write
    v = '0; v.m0_req = 1; v.m0_we = 1; v.m0_addr = 32'h66000010; v.m0_wd = 32'hDEADBEEF; v.gnt0 = 1; vecs.push_back(v);
    v = '0; v.mem_we = 1; v.mem_addr = 32'h66000010; v.mem_wd = 32'hDEADBEEF; vecs.push_back(v);
    v = '0; v.rv0 = 1; vecs.push_back(v);
    // Transaction 2: m1 reads the same word back
    v = '0; v.m1_req = 1; v.m1_addr = 32'h66000010; v.gnt1 = 1; vecs.push_back(v);
    v = '0; v.mem_rd = 32'hDEADBEEF; v.mem_addr = 32'h66000010; vecs.push_back(v);
    v = '0; v.rv1 = 1; v.rd1 = 32'hDEADBEEF; vecs.push_back(v);
    // Transaction 3: m0 write above limit; m1 request held while busy is ignored
    v = '0; v.m0_req = 1; v.m0_we = 1; v.m0_addr = 32'h66000100; v.m0_wd = 32'h11111111; v.gnt0 = 1; vecs.push_back(v);
    v = '0; v.m1_req = 1; v.m1_addr = 32'h66000006; v.mem_addr = 32'h66000100; v.mem_wd = 32'h11111111; vecs.push_back(v);
    v = '0; v.m1_req = 1; v.m1_addr = 32'h66000006; v.rv0 = 1; v.err0 = 1; vecs.push_back(v);
    // Transaction 4: m1 misaligned read, memory data must not leak
    v = '0; v.m1_req = 1; v.m1_addr = 32'h66000006; v.mem_rd = 32'hAAAAAAAA; v.gnt1 = 1; vecs.push_back(v);
    v = '0; v.mem_rd = 32'hAAAAAAAA; v.mem_addr = 32'h66000006; vecs.push_back(v);
    v = '0; v.rv1 = 1; v.err1 = 1; vecs.push_back(v);
    // Transactions 5/6: both request, pointer at m0; m0 reads the limit word, then m1 writes base
    v = '0; v.m0_req = 1; v.m0_addr = 32'h660000FC; v.m1_req = 1; v.m1_we = 1; v.m1_addr = 32'h66000000;
    v.m1_wd = 32'h5A5A5A5A; v.gnt0 = 1; vecs.push_back(v);
    v = '0; v.m1_req = 1; v.m1_we = 1; v.m1_addr = 32'h66000000; v.m1_wd = 32'h5A5A5A5A;
    v.mem_rd = 32'hCAFEF00D; v.mem_addr = 32'h660000FC; vecs.push_back(v);
    v = '0; v.m1_req = 1; v.m1_we = 1; v.m1_addr = 32'h66000000; v.m1_wd = 32'h5A5A5A5A;
    v.rv0 = 1; v.rd0 = 32'hCAFEF00D; vecs.push_back(v);
    v = '0; v.m1_req = 1; v.m1_we = 1; v.m1_addr = 32'h66000000; v.m1_wd = 32'h5A5A5A5A; v.gnt1 = 1; vecs.push_back(v);
    v = '0; v.mem_we = 1; v.mem_addr = 32'h66000000; v.mem_wd = 32'h5A5A5A5A; vecs.push_back(v);
    v = '0; v.rv1 = 1; vecs.push_back(v);
    // Transaction 7: write just below base
    v = '0; v.m0_req = 1; v.m0_we = 1; v.m0_addr = 32'h65FFFFFC; v.m0_wd = 32'h22222222; v.gnt0 = 1; vecs.push_back(v);
    v = '0; v.mem_addr = 32'h65FFFFFC; v.mem_wd = 32'h22222222; vecs.push_back(v);
    v = '0; v.rv0 = 1; v.err0 = 1; vecs.push_back(v);
    v = '0; vecs.push_back(v);

    // Reset state
    do_reset();
    #1;
    chk("reset_state", state_o, 2'd0);
    chk("reset_outputs", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, mem_we_o}, 0);
    chk("reset_buses", m0_rd_o | m1_rd_o | mem_addr_o | mem_wd_o, 0);
    @(posedge clk_i);
    #1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
      next_cycle();
    end
    clear_inputs();

    // Both requesters continuously from reset: m0, m1, m0, m1 every 3 cycles
    do_reset();
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    m0_req_i = 1; m0_addr_i = 32'h66000000;
    m1_req_i = 1; m1_addr_i = 32'h66000004;
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("alt_slot_c%0d", c), m0_gnt_o | m1_gnt_o, (c % 3) == 0);
      if (m0_gnt_o || m1_gnt_o) begin
        if (exp_q.size() == 0) chk($sformatf("alt_extra_c%0d", c), 1, 0);
        else chk($sformatf("alt_id_c%0d", c), m1_gnt_o, exp_q.pop_front());
      end
      next_cycle();
    end
    chk("alt_remaining", exp_q.size(), 0);
    clear_inputs();

    // Reset during ACCESS of a valid m1 write, with the pointer favouring m1
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h66000008;
    #1 chk("rst_pre_gnt0", m0_gnt_o, 1);
    next_cycle();
    clear_inputs();
    next_cycle();
    next_cycle();
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h66000020; m1_wd_i = 32'h77777777;
    #1 chk("rst_pre_gnt1", m1_gnt_o, 1);
    next_cycle();
    clear_inputs();
    #1 chk("rst_access_we", mem_we_o, 1);
    rst_i = 1'b1;
    #1;
    chk("rst_async_we", mem_we_o, 0);
    chk("rst_async_addr", mem_addr_o, 0);
    chk("rst_async_state", state_o, 2'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    m0_req_i = 1; m0_addr_i = 32'h66000030;
    m1_req_i = 1; m1_addr_i = 32'h66000034;
    #1;
    chk("rst_no_rvalid", m0_rvalid_o | m1_rvalid_o, 0);
    chk("rst_next_gnt0", m0_gnt_o, 1);
    chk("rst_next_gnt1", m1_gnt_o, 0);
    next_cycle();
    m0_req_i = 0;
    #1;
    chk("rst_lat_addr", mem_addr_o, 32'h66000030);
    chk("rst_lat_no_rvalid", m0_rvalid_o | m1_rvalid_o, 0);
    next_cycle();
    #1;
    chk("rst_lat_rvalid0", m0_rvalid_o, 1);
    chk("rst_lat_rvalid1", m1_rvalid_o, 0);
    clear_inputs();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
